mreq_rr_arbiter: RTL
====================

MREQ_RR_ARBITER -- requirements
Module: mreq_rr_arbiter

Interface
REQ-001 SHALL have parameter M, default 4, number of masters (2..8).
REQ-002 SHALL have parameter RID_W, default 3, log2 of read-ID FIFO depth (8 entries).
REQ-003 SHALL have parameter TIMEOUT, default 255, read-response watchdog limit in cycles.
REQ-004 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset, asynchronous, active-low.
REQ-005 SHALL have ports: m_req in M request per master; m_cmd in M (1=write, 0=read); m_addr in 32*M; m_wdata in 32*M; m_ack out M; m_resp out M; m_rdata out 32*M.
REQ-006 SHALL have ports: s_req out 1; s_cmd out 1; s_addr out 32; s_wdata out 32; s_ack in 1; s_resp in 1; s_rdata in 32.
REQ-007 SHALL have ports: grant_o out M one-hot current grant; err_o out 1 one-cycle error pulse.

Function
REQ-008 SHALL implement FSM with states IDLE and BUSY.
REQ-009 In IDLE with any m_req set, SHALL pick the first requester after last_grant in ascending circular order, register it in grant_o, and enter BUSY next cycle (1-cycle arbitration latency).
REQ-010 In IDLE with no m_req set, SHALL stay in IDLE, grant_o=0, s_req=0.
REQ-011 In BUSY, SHALL drive s_req/s_cmd/s_addr/s_wdata combinationally from the granted master.
REQ-012 In BUSY, SHALL route s_ack combinationally to m_ack of the granted master only; all other m_ack=0.
REQ-013 On s_req & s_ack, SHALL set last_grant to the granted index, clear grant_o, and return to IDLE; the next arbitration occurs in the following cycle.
REQ-014 On an accepted read (s_req & s_ack & !s_cmd), SHALL push the granted index into the read-ID FIFO.
REQ-015 While granted master requests a read and the FIFO is full, SHALL hold s_req=0 and m_ack=0 until a pop frees space; writes are never blocked.
REQ-016 On s_resp, SHALL pop the FIFO head and assert m_resp and m_rdata=s_rdata for that master in the same cycle; other m_resp=0.
REQ-017 Simultaneous push and pop SHALL be supported when the FIFO is not full; on full, pop then push in the same cycle is not required.
REQ-018 s_resp with the FIFO empty SHALL be dropped and SHALL pulse err_o for one cycle.
REQ-019 If the granted master drops m_req in BUSY, SHALL return to IDLE without updating last_grant and without error.
REQ-020 After reset, last_grant SHALL be M-1, so master 0 wins first.

Reset
REQ-021 On rst_i low, SHALL asynchronously force state=IDLE, grant_o=0, last_grant=M-1, FIFO empty, watchdog=0, err_o=0.
REQ-022 Outstanding read IDs at reset SHALL be discarded; later s_resp SHALL follow REQ-018.

Configuration
REQ-023 Macro MREQ_RR_ARBITER_WDOG_EN SHALL enable the read-response watchdog.
REQ-024 With the macro, SHALL count cycles while the FIFO is non-empty, clear the count on each pop, and on reaching TIMEOUT pulse err_o and restart the count.
REQ-025 Without the macro, SHALL include no counter logic; err_o SHALL be driven only per REQ-018.

Structure
REQ-026 Shared package mreq_arb_pkg SHALL hold the FSM state encoding, the CMD_RD/CMD_WR constants, and the default parameter values.
REQ-027 The read-ID FIFO SHALL be a sub-module named rid_fifo, parameterised by width clog2(M) and depth 2**RID_W.

Verification
REQ-028 Masters 0 and 2 read simultaneously after reset, slave acks immediately -> grant order 0, then 2; two FIFO pushes.
REQ-029 All 4 masters request continuously, slave always acks -> grants rotate 0,1,2,3,0, each ack 2 cycles apart.
REQ-030 Master 1 issues 9 reads with no slave response -> 8 acked, 9th held with s_req=0; one s_resp -> 9th acked next cycle.
REQ-031 Responses 0xA5A5A5A5 then 0x5A5A5A5A for reads by masters 3 then 1 -> m_resp[3] carries 0xA5A5A5A5, then m_resp[1] carries 0x5A5A5A5A.
REQ-032 s_resp with an empty FIFO -> err_o high for exactly 1 cycle; with WDOG_EN, one read unanswered for 255 cycles -> err_o pulse.
REQ-033 rst_i low mid-BUSY with 3 reads outstanding -> grant_o=0 immediately; next request from master 0 is granted first.

Source files
------------

// File: rtl/mreq_arb_pkg.sv
// Shared definitions for the multi-master round-robin arbiter: FSM state
// encoding, command constants and default parameter values.
package mreq_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;

  localparam int M_DEFAULT       = 4;
  localparam int RID_W_DEFAULT   = 3;
  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mreq_rr_arbiter_rid_fifo.sv
// Read-ID FIFO: remembers which master issued each outstanding read so the
// slave's in-order responses can be steered back to the right requester.
module rid_fifo #(
  parameter int W          = 2,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [W-1:0]          mem_q [DEPTH];
  logic                  do_push, do_pop;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mreq_rr_arbiter.sv
// Round-robin arbiter funnelling M masters onto one slave port, with in-order
// read-response routing. Define MREQ_RR_ARBITER_WDOG_EN for the response watchdog.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no grant; picks next requester after last_grant
// ST_BUSY | grant_o held; slave port driven from granted master
module mreq_rr_arbiter
  import mreq_arb_pkg::*;
#(
  parameter int M       = M_DEFAULT,
  parameter int RID_W   = RID_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [M-1:0]    m_req,
  input  logic [M-1:0]    m_cmd,
  input  logic [32*M-1:0] m_addr,
  input  logic [32*M-1:0] m_wdata,
  output logic [M-1:0]    m_ack,
  output logic [M-1:0]    m_resp,
  output logic [32*M-1:0] m_rdata,
  output logic            s_req,
  output logic            s_cmd,
  output logic [31:0]     s_addr,
  output logic [31:0]     s_wdata,
  input  logic            s_ack,
  input  logic            s_resp,
  input  logic [31:0]     s_rdata,
  output logic [M-1:0]    grant_o,
  output logic            err_o
);

  localparam int IDX_W = $clog2(M);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(M - 1);

  arb_state_e       state_q, state_d;
  logic [M-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] cand, pick_idx, fifo_head;
  logic             pick_vld;
  logic             g_req, g_cmd;
  logic [31:0]      g_addr, g_wdata;
  logic             rd_block, s_req_int, accept, push, pop, resp_err;
  logic             fifo_full, fifo_empty;

  // Circular search starting just after the last master served.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= M; k++) begin
      cand = IDX_W'((int'(last_q) + k) % M);
      if (!pick_vld && m_req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    g_req   = 1'b0;
    g_cmd   = CMD_RD;
    g_addr  = '0;
    g_wdata = '0;
    for (int i = 0; i < M; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        g_req   = m_req[i];
        g_cmd   = m_cmd[i];
        g_addr  = m_addr[32*i +: 32];
        g_wdata = m_wdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    s_req_int = 1'b0;
    accept    = 1'b0;
    push      = 1'b0;
    // Reads stall while no ID slot is free; writes never need one.
    rd_block  = (g_cmd == CMD_RD) && fifo_full;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d           = ST_BUSY;
          gidx_d            = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!g_req) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else begin
          s_req_int = !rd_block;
          accept    = s_req_int && s_ack;
          if (accept) begin
            state_d = ST_IDLE;
            grant_d = '0;
            last_d  = gidx_q;
            push    = (g_cmd == CMD_RD);
          end
        end
      end
    endcase
  end

  always_comb begin
    s_req   = s_req_int;
    s_cmd   = (state_q == ST_BUSY) ? g_cmd : CMD_RD;
    s_addr  = (state_q == ST_BUSY) ? g_addr : '0;
    s_wdata = (state_q == ST_BUSY) ? g_wdata : '0;
    m_ack   = '0;
    for (int i = 0; i < M; i++) begin
      m_ack[i] = accept && (gidx_q == IDX_W'(i));
    end
  end

  always_comb begin
    pop      = s_resp && !fifo_empty;
    resp_err = s_resp && fifo_empty;
    m_resp   = '0;
    m_rdata  = '0;
    for (int i = 0; i < M; i++) begin
      if (pop && (fifo_head == IDX_W'(i))) begin
        m_resp[i]           = 1'b1;
        m_rdata[32*i +: 32] = s_rdata;
      end
    end
  end

  rid_fifo #(
    .W          (IDX_W),
    .DEPTH_LOG2 (RID_W)
  ) u_rid_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (gidx_q),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef MREQ_RR_ARBITER_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            wdog_hit;

  // Counts only while reads are outstanding; any response restarts the wait.
  always_comb begin
    wdog_d   = wdog_q;
    wdog_hit = 1'b0;
    if (pop || fifo_empty) begin
      wdog_d = '0;
    end else if (wdog_q == WD_LAST) begin
      wdog_d   = '0;
      wdog_hit = 1'b1;
    end else begin
      wdog_d = wdog_q + WD_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end

  assign err_d = resp_err || wdog_hit;
`else
  assign err_d = resp_err;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= LAST_RST;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign grant_o = grant_q;
  assign err_o   = err_q;

endmodule
